// File: rtl/mul_arbiter.sv
// Two-requester arbiter sharing one operand pair and one product register; fixed 4-state walk
// IDLE->LOAD->MULTIPLY->DISPLAY, round-robin pointer on contention, no request queueing.
module mul_arbiter #(
   parameter int p_data_width = 7
) (
   input  logic                      i_w_clk,
   input  logic                      i_w_reset,
   input  logic                      i_w_req0,
   input  logic                      i_w_req1,
   input  logic [p_data_width-1:0]   i_w_a0,
   input  logic [p_data_width-1:0]   i_w_b0,
   input  logic [p_data_width-1:0]   i_w_a1,
   input  logic [p_data_width-1:0]   i_w_b1,
   output logic                      o_w_grant0,
   output logic                      o_w_grant1,
   output logic                      o_w_done0,
   output logic                      o_w_done1,
   output logic [2*p_data_width-1:0] o_w_out,
   output logic                      o_w_busy,
   output logic [7:0]                o_w_ops_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      MULTIPLY = 2'd2,
      DISPLAY  = 2'd3
   } state_t;

   state_t                    state, state_nxt;
   logic                      sel, sel_nxt;
   logic                      ptr;
   logic [p_data_width-1:0]   reg_a, reg_b;
   logic [2*p_data_width-1:0] reg_c;
   logic [7:0]                ops_count;

   always_ff @(posedge i_w_clk) begin
      if (i_w_reset) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      case (state)
         IDLE: begin
            if (i_w_req0 || i_w_req1) begin
               state_nxt = LOAD;
               // ptr only breaks ties; a lone requester always wins
               sel_nxt   = (i_w_req0 && i_w_req1) ? ptr : i_w_req1;
            end
         end
         LOAD:     state_nxt = MULTIPLY;
         MULTIPLY: state_nxt = DISPLAY;
         DISPLAY:  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_w_clk) begin
      if (i_w_reset) begin
         sel       <= 1'b0;
         ptr       <= 1'b0;
         reg_a     <= '0;
         reg_b     <= '0;
         reg_c     <= '0;
         ops_count <= '0;
      end else begin
         sel <= sel_nxt;
         case (state)
            LOAD: begin
               reg_a <= sel ? i_w_a1 : i_w_a0;
               reg_b <= sel ? i_w_b1 : i_w_b0;
            end
            MULTIPLY: reg_c <= (2*p_data_width)'(reg_a) * (2*p_data_width)'(reg_b);
            DISPLAY: begin
               ops_count <= ops_count + 8'd1;
               ptr       <= ~sel;
            end
            default: ;
         endcase
      end
   end

   assign o_w_busy      = (state != IDLE);
   assign o_w_grant0    = o_w_busy & ~sel;
   assign o_w_grant1    = o_w_busy & sel;
   assign o_w_done0     = (state == DISPLAY) & ~sel;
   assign o_w_done1     = (state == DISPLAY) & sel;
   assign o_w_out       = (state == DISPLAY) ? reg_c : '0;
   assign o_w_ops_count = ops_count;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: expected (requester, product) pairs are queued as stimulus is
// applied and retired by a monitor on every done pulse; directed steps check timing and reset.
module tb_mul_arbiter;

   localparam int W = 7;

   typedef struct {
      logic           who;
      logic [2*W-1:0] prod;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0, req1;
   logic [W-1:0]   a0, b0, a1, b1;
   logic           grant0, grant1, done0, done1, busy;
   logic [2*W-1:0] out;
   logic [7:0]     ops_count;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mul_arbiter #(.p_data_width(W)) dut (
      .i_w_clk       (clk),
      .i_w_reset     (rst),
      .i_w_req0      (req0),
      .i_w_req1      (req1),
      .i_w_a0        (a0),
      .i_w_b0        (b0),
      .i_w_a1        (a1),
      .i_w_b1        (b1),
      .o_w_grant0    (grant0),
      .o_w_grant1    (grant1),
      .o_w_done0     (done0),
      .o_w_done1     (done1),
      .o_w_out       (out),
      .o_w_busy      (busy),
      .o_w_ops_count (ops_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic who, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.who  = who;
      e.prod = (2*W)'(a) * (2*W)'(b);
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         seen = done0 | done1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) tick();
      rst = 1'b0;
   endtask

   // Scoreboard retirement and mutual-exclusion of grants, sampled mid-cycle
   always @(negedge clk) begin
      check("grant_excl", 32'(grant0 & grant1), 32'd0);
      if (done0 || done1) begin
         check("done_excl", 32'(done0 & done1), 32'd0);
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(sb_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_who", 32'(done1), 32'(e.who));
            check("sb_prod", 32'(out), 32'(e.prod));
         end
      end
   end

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;

      // Reset held for 10 cycles: everything quiet
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_out", 32'(out), 32'd0);
         check("rst_grants", 32'({grant0, grant1, done0, done1}), 32'd0);
         check("rst_count", 32'(ops_count), 32'd0);
      end
      rst = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      // Single request from 0: exact cycle-by-cycle timing
      req0 = 1'b1; a0 = 7'd5; b0 = 7'd6;
      push(1'b0, 7'd5, 7'd6);
      tick();
      check("s_load_grant0", 32'(grant0), 32'd1);
      check("s_load_busy", 32'(busy), 32'd1);
      check("s_load_done", 32'(done0), 32'd0);
      req0 = 1'b0;
      tick();
      check("s_mul_grant0", 32'(grant0), 32'd1);
      check("s_mul_out", 32'(out), 32'd0);
      tick();
      check("s_disp_grant0", 32'(grant0), 32'd1);
      check("s_disp_done0", 32'(done0), 32'd1);
      check("s_disp_out", 32'(out), 32'd30);
      tick();
      check("s_after_grant0", 32'(grant0), 32'd0);
      check("s_after_done0", 32'(done0), 32'd0);
      check("s_after_count", 32'(ops_count), 32'd1);
      check("s_after_out", 32'(out), 32'd0);

      // Contention straight after reset: 0 first, then 1
      do_reset(2);
      req0 = 1'b1; a0 = 7'd7;   b0 = 7'd3;
      req1 = 1'b1; a1 = 7'd127; b1 = 7'd127;
      push(1'b0, 7'd7, 7'd3);
      push(1'b1, 7'd127, 7'd127);
      tick();
      check("c_first_grant0", 32'(grant0), 32'd1);
      check("c_first_grant1", 32'(grant1), 32'd0);
      wait_done("c_wait0", 10);
      req0 = 1'b0;
      wait_done("c_wait1", 10);
      check("c_out_max", 32'(out), 32'h3F01);
      req1 = 1'b0;
      tick();
      check("c_count", 32'(ops_count), 32'd2);
      check("c_busy", 32'(busy), 32'd0);

      // Operand change after LOAD must not leak into the product
      req1 = 1'b1; a1 = 7'd4; b1 = 7'd2;
      push(1'b1, 7'd4, 7'd2);
      tick();
      check("o_load_grant1", 32'(grant1), 32'd1);
      req1 = 1'b0;
      tick();
      b1 = 7'd9;
      wait_done("o_wait", 10);
      check("o_out", 32'(out), 32'd8);
      tick();
      check("o_count", 32'(ops_count), 32'd3);

      // Reset in MULTIPLY aborts with no done and no count bump
      do_reset(1);
      req0 = 1'b1; a0 = 7'd3; b0 = 7'd3;
      tick();
      req0 = 1'b0;
      tick();
      check("a_mul_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("a_busy", 32'(busy), 32'd0);
      check("a_grant0", 32'(grant0), 32'd0);
      check("a_out", 32'(out), 32'd0);
      check("a_count", 32'(ops_count), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("a_idle_count", 32'(ops_count), 32'd0);
      check("a_idle_busy", 32'(busy), 32'd0);

      // Both held for 256 operations: strict alternation, count wraps to 0
      req0 = 1'b1; a0 = 7'd11;  b0 = 7'd13;
      req1 = 1'b1; a1 = 7'd127; b1 = 7'd2;
      for (int i = 0; i < 256; i++) begin
         if (i % 2 == 0) push(1'b0, 7'd11, 7'd13);
         else            push(1'b1, 7'd127, 7'd2);
      end
      begin
         int n_done;
         n_done = 0;
         for (int c = 0; c < 1200 && n_done < 256; c++) begin
            tick();
            if (done0 || done1) begin
               n_done++;
               if (n_done == 128) check("r_mid_count", 32'(ops_count), 32'd127);
            end
         end
         check("r_done_total", 32'(n_done), 32'd256);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      check("r_wrap_count", 32'(ops_count), 32'd0);
      check("r_busy", 32'(busy), 32'd0);
      tick();
      check("r_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
